// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit.
//  - 5-bit operation codes delivered by the ALU controller
//  - 4-bit CR16-style condition codes
//  - bit positions inside the {C,L,F,Z,N} flag register
//  - handshake FSM state encodings
//  - cond_true(): evaluates a condition code against a flag value
package alu_pkg;

    // Operation codes
    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_SUB   = 5'b00001;  // also cmp when only flags are consumed
    localparam logic [4:0] OP_MUL   = 5'b00010;
    localparam logic [4:0] OP_AND   = 5'b00011;
    localparam logic [4:0] OP_OR    = 5'b00100;
    localparam logic [4:0] OP_XOR   = 5'b00101;
    localparam logic [4:0] OP_XNOR  = 5'b00110;
    localparam logic [4:0] OP_SCOND = 5'b00111;
    localparam logic [4:0] OP_MOV   = 5'b01000;
    localparam logic [4:0] OP_MOVB  = 5'b01001;
    localparam logic [4:0] OP_NOT   = 5'b01010;
    localparam logic [4:0] OP_LSH   = 5'b01011;
    localparam logic [4:0] OP_LSHL  = 5'b01100;
    localparam logic [4:0] OP_LSHR  = 5'b01101;
    localparam logic [4:0] OP_ASHU  = 5'b01110;
    localparam logic [4:0] OP_ASHR  = 5'b01111;
    localparam logic [4:0] OP_BCOND = 5'b10000;
    localparam logic [4:0] OP_JCOND = 5'b10001;

    // Condition codes
    localparam logic [3:0] CC_EQ = 4'h0;
    localparam logic [3:0] CC_NE = 4'h1;
    localparam logic [3:0] CC_CS = 4'h2;
    localparam logic [3:0] CC_CC = 4'h3;
    localparam logic [3:0] CC_HI = 4'h4;
    localparam logic [3:0] CC_LS = 4'h5;
    localparam logic [3:0] CC_GT = 4'h6;
    localparam logic [3:0] CC_LE = 4'h7;
    localparam logic [3:0] CC_FS = 4'h8;
    localparam logic [3:0] CC_FC = 4'h9;
    localparam logic [3:0] CC_LO = 4'hA;
    localparam logic [3:0] CC_HS = 4'hB;
    localparam logic [3:0] CC_LT = 4'hC;
    localparam logic [3:0] CC_GE = 4'hD;
    localparam logic [3:0] CC_UC = 4'hE;
    localparam logic [3:0] CC_NV = 4'hF;

    // Flag register bit positions: {C,L,F,Z,N}
    localparam int FLAG_C = 4;
    localparam int FLAG_L = 3;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    // Handshake FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    function automatic logic cond_true(input logic [3:0] cc, input logic [4:0] fl);
        logic c, l, f, z, n;
        c = fl[FLAG_C];
        l = fl[FLAG_L];
        f = fl[FLAG_F];
        z = fl[FLAG_Z];
        n = fl[FLAG_N];
        case (cc)
            CC_EQ:   return z;
            CC_NE:   return ~z;
            CC_CS:   return c;
            CC_CC:   return ~c;
            CC_HI:   return l;
            CC_LS:   return ~l;
            CC_GT:   return n;
            CC_LE:   return ~n;
            CC_FS:   return f;
            CC_FC:   return ~f;
            CC_LO:   return ~l & ~z;
            CC_HS:   return l | z;
            CC_LT:   return ~n & ~z;
            CC_GE:   return n | z;
            CC_UC:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add multiplier, one partial product per clock.
//  clk      in   clock, rising edge
//  reset    in   asynchronous, active-high; discards any partial product
//  start    in   load a/b and begin ITERS iterations on this edge
//  abort    in   synchronous cancel of an in-progress multiply
//  a, b     in   multiplicand / multiplier
//  done     out  high during the cycle whose edge completes the final iteration
//  product  out  low WIDTH bits of a*b; valid while done is high
module alu_mul_seq #(
    parameter int WIDTH = 16,
    parameter int ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CW = $clog2(ITERS + 1);

    logic             busy;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;

    // Accumulator value after the current iteration; on the final iteration
    // this is the finished product, so the consumer can capture it directly.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign done    = busy && (count == CW'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start) begin
            busy   <= 1'b1;
            count  <= CW'(ITERS);
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
            if (count == CW'(1)) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: consumes the 5-bit ALU control code, computes the
// selected operation, holds the {C,L,F,Z,N} flag register and evaluates
// conditions for Scond/Bcond/Jcond. Multiply runs on alu_mul_seq.
//  clk        in   clock, rising edge
//  reset      in   asynchronous, active-high
//  in_valid   in   operation presented
//  in_ready   out  unit can accept an operation
//  alu_cont   in   operation code
//  dst        in   destination operand (PC for Bcond/Jcond)
//  src        in   source operand / immediate / Scond condition in [3:0]
//  cond       in   condition code for Bcond/Jcond
//  flag_we    in   operation updates the flags (add/sub only)
//  flush      in   synchronous abort of in-flight op and pending result
//  out_valid  out  result available
//  out_ready  in   consumer takes the result
//  result     out  operation result
//  flags      out  {C,L,F,Z,N}
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MUL_ITERS = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       alu_cont,
    input  logic [WIDTH-1:0] dst,
    input  logic [WIDTH-1:0] src,
    input  logic [3:0]       cond,
    input  logic             flag_we,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);

    logic [0:0]       state;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] alu_res;
    logic [4:0]       next_flags;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] diff;
    logic [4:0]       right_amt;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] lsr;
    logic [WIDTH-1:0] asr;

    // A pending result may be replaced on the same edge it is taken, which
    // allows back-to-back issue. flush blocks acceptance for its cycle.
    assign in_ready  = (state == ST_IDLE) && (!out_valid || out_ready) && !flush;
    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (alu_cont == OP_MUL);

    alu_mul_seq #(
        .WIDTH (WIDTH),
        .ITERS (MUL_ITERS)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .abort   (flush),
        .a       (dst),
        .b       (src),
        .done    (mul_done),
        .product (mul_product)
    );

    // Right shifts take the negated 5-bit amount: src[4:0]=1_0000 gives 16,
    // which empties a logical shift and sign-fills an arithmetic one.
    assign right_amt = ~src[4:0] + 5'd1;
    assign shl       = dst << src[3:0];
    assign lsr       = dst >> right_amt;
    assign asr       = $signed(dst) >>> right_amt;
    assign sum       = {1'b0, dst} + {1'b0, src};
    assign diff      = dst - src;

    // NOTE: every always_comb output gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        alu_res    = dst;
        next_flags = flags;
        case (alu_cont)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                next_flags[FLAG_C] = sum[WIDTH];
                next_flags[FLAG_F] = (dst[WIDTH-1] == src[WIDTH-1]) &&
                                     (sum[WIDTH-1] != dst[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                next_flags[FLAG_Z] = (dst == src);
                next_flags[FLAG_L] = (dst < src);
                next_flags[FLAG_N] = ($signed(dst) < $signed(src));
                next_flags[FLAG_F] = (dst[WIDTH-1] != src[WIDTH-1]) &&
                                     (diff[WIDTH-1] != dst[WIDTH-1]);
            end
            OP_AND:   alu_res = dst & src;
            OP_OR:    alu_res = dst | src;
            OP_XOR:   alu_res = dst ^ src;
            OP_XNOR:  alu_res = ~(dst ^ src);
            OP_SCOND: alu_res = {{(WIDTH-1){1'b0}}, cond_true(src[3:0], flags)};
            OP_MOV:   alu_res = src;
            OP_MOVB:  alu_res = {dst[7:0], src[7:0]};
            OP_NOT:   alu_res = ~dst;
            OP_LSH:   alu_res = src[4] ? lsr : shl;
            OP_LSHL:  alu_res = shl;
            OP_LSHR:  alu_res = lsr;
            OP_ASHU:  alu_res = src[4] ? asr : shl;
            OP_ASHR:  alu_res = asr;
            OP_BCOND: alu_res = cond_true(cond, flags) ? sum[WIDTH-1:0] : dst;
            OP_JCOND: alu_res = cond_true(cond, flags) ? src : dst;
            default:  alu_res = dst;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
        end else if (accept) begin
            if (alu_cont == OP_MUL) begin
                // Any earlier result is transferred on this edge.
                state     <= ST_MUL;
                out_valid <= 1'b0;
            end else begin
                result    <= alu_res;
                out_valid <= 1'b1;
                if (flag_we) begin
                    flags <= next_flags;
                end
            end
        end else if ((state == ST_MUL) && mul_done) begin
            state     <= ST_IDLE;
            result    <= mul_product;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alu_cont = '0;
    logic [15:0] dst = '0;
    logic [15:0] src = '0;
    logic [3:0]  cond = '0;
    logic        flag_we = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic [4:0]  flags;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [4:0]  code;
        logic [15:0] d;
        logic [15:0] s;
        logic [3:0]  c;
        logic [15:0] exp;
    } vec_t;

    alu_exec_unit #(.WIDTH(16), .MUL_ITERS(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_cont  (alu_cont),
        .dst       (dst),
        .src       (src),
        .cond      (cond),
        .flag_we   (flag_we),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operation and let it be accepted on the next usable edge.
    task automatic issue(input logic [4:0] code, input logic [15:0] d, input logic [15:0] s,
                         input logic [3:0] c, input logic fwe);
        alu_cont = code;
        dst      = d;
        src      = s;
        cond     = c;
        flag_we  = fwe;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !in_ready; k++) step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready_timeout: in_ready=%b required 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        flag_we  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h want 0000", result); end
        checks++;
        if (flags !== 5'h00) begin errors++; $display("FAIL reset_flags: got %h want 00", flags); end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_add_flags();
        issue(OP_ADD, 16'hFFFF, 16'h0001, 4'h0, 1'b1);
        checks++;
        if (result !== 16'h0000) begin errors++; $display("FAIL add_result: got %h want 0000", result); end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid: got %b want 1", out_valid); end
        // C=1, F=0, others untouched from reset
        checks++;
        if (flags !== 5'b10000) begin errors++; $display("FAIL add_flags: got %b want 10000", flags); end
    endtask

    task automatic test_cmp_branch();
        issue(OP_SUB, 16'h0003, 16'h0005, 4'h0, 1'b1);
        checks++;
        if (result !== 16'hFFFE) begin errors++; $display("FAIL cmp_result: got %h want fffe", result); end
        // C kept 1 from the add; L=1 N=1 Z=0 F=0
        checks++;
        if (flags !== 5'b11001) begin errors++; $display("FAIL cmp_flags: got %b want 11001", flags); end
        issue(OP_BCOND, 16'h0100, 16'h0010, CC_LO, 1'b0);
        checks++;
        if (result !== 16'h0100) begin errors++; $display("FAIL bcond_lo_result: got %h want 0100", result); end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bcond_out_valid: got %b want 1", out_valid); end
        issue(OP_BCOND, 16'h0100, 16'h0010, CC_HS, 1'b0);
        checks++;
        if (result !== 16'h0110) begin errors++; $display("FAIL bcond_hs_result: got %h want 0110", result); end
        checks++;
        if (flags !== 5'b11001) begin errors++; $display("FAIL bcond_flags_kept: got %b want 11001", flags); end
    endtask

    // Flags at this point: C=1 L=1 F=0 Z=0 N=1
    task automatic test_single_cycle_ops();
        vec_t v [18];
        v[0]  = '{OP_AND,   16'hF0F0, 16'h3C3C, 4'h0,  16'h3030};
        v[1]  = '{OP_OR,    16'hF0F0, 16'h3C3C, 4'h0,  16'hFCFC};
        v[2]  = '{OP_XOR,   16'hF0F0, 16'h3C3C, 4'h0,  16'hCCCC};
        v[3]  = '{OP_XNOR,  16'hF0F0, 16'h3C3C, 4'h0,  16'h3333};
        v[4]  = '{OP_MOV,   16'hF0F0, 16'h3C3C, 4'h0,  16'h3C3C};
        v[5]  = '{OP_MOVB,  16'h12AB, 16'h34CD, 4'h0,  16'hABCD};
        v[6]  = '{OP_NOT,   16'hF0F0, 16'h0000, 4'h0,  16'h0F0F};
        v[7]  = '{OP_SUB,   16'h0005, 16'h0007, 4'h0,  16'hFFFE};
        v[8]  = '{5'b10010, 16'hABCD, 16'h1111, 4'h0,  16'hABCD};
        v[9]  = '{OP_SCOND, 16'h0000, 16'h0000, 4'h0,  16'h0000};
        v[10] = '{OP_SCOND, 16'h0000, 16'h0001, 4'h0,  16'h0001};
        v[11] = '{OP_SCOND, 16'h0000, 16'h0006, 4'h0,  16'h0001};
        v[12] = '{OP_SCOND, 16'h0000, 16'h0005, 4'h0,  16'h0000};
        v[13] = '{OP_SCOND, 16'h0000, 16'h000C, 4'h0,  16'h0000};
        v[14] = '{OP_SCOND, 16'h0000, 16'h000F, 4'h0,  16'h0000};
        v[15] = '{OP_JCOND, 16'h0100, 16'h0200, CC_UC, 16'h0200};
        v[16] = '{OP_JCOND, 16'h0100, 16'h0200, CC_CC, 16'h0100};
        v[17] = '{OP_BCOND, 16'h0100, 16'h0020, CC_CS, 16'h0120};
        for (int i = 0; i < 18; i++) begin
            issue(v[i].code, v[i].d, v[i].s, v[i].c, 1'b0);
            checks++;
            if (result !== v[i].exp) begin
                errors++;
                $display("FAIL op_vec%0d code=%b: got %h want %h", i, v[i].code, result, v[i].exp);
            end
        end
        checks++;
        if (flags !== 5'b11001) begin errors++; $display("FAIL ops_flags_kept: got %b want 11001", flags); end
    endtask

    task automatic test_shifts();
        vec_t v [12];
        v[0]  = '{OP_ASHU, 16'h8000, 16'hFFFC, 4'h0, 16'hF800};
        v[1]  = '{OP_LSH,  16'h8000, 16'hFFFC, 4'h0, 16'h0800};
        v[2]  = '{OP_LSH,  16'h8000, 16'h0003, 4'h0, 16'h0000};
        v[3]  = '{OP_LSH,  16'h0001, 16'h0003, 4'h0, 16'h0008};
        v[4]  = '{OP_ASHU, 16'h0001, 16'h0004, 4'h0, 16'h0010};
        v[5]  = '{OP_LSHL, 16'h00F0, 16'h0004, 4'h0, 16'h0F00};
        v[6]  = '{OP_LSHR, 16'h8000, 16'h001F, 4'h0, 16'h4000};
        v[7]  = '{OP_LSHR, 16'h8000, 16'h0010, 4'h0, 16'h0000};
        v[8]  = '{OP_ASHR, 16'h8000, 16'h0010, 4'h0, 16'hFFFF};
        v[9]  = '{OP_ASHR, 16'h4000, 16'h0010, 4'h0, 16'h0000};
        v[10] = '{OP_ASHR, 16'h8000, 16'h001C, 4'h0, 16'hF800};
        v[11] = '{OP_ASHU, 16'h8000, 16'hFFF0, 4'h0, 16'hFFFF};
        for (int i = 0; i < 12; i++) begin
            issue(v[i].code, v[i].d, v[i].s, v[i].c, 1'b0);
            checks++;
            if (result !== v[i].exp) begin
                errors++;
                $display("FAIL shift_vec%0d code=%b: got %h want %h", i, v[i].code, result, v[i].exp);
            end
        end
    endtask

    task automatic test_multiply();
        int busy_cycles;
        busy_cycles = 0;
        // flag_we set on purpose: multiply must not touch the flags
        issue(OP_MUL, 16'h0012, 16'h0034, 4'h0, 1'b1);
        for (int k = 0; k < 40 && !out_valid; k++) begin
            if (!in_ready) busy_cycles++;
            step();
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mul_timeout: out_valid=%b want 1", out_valid); end
        checks++;
        if (busy_cycles != 16) begin errors++; $display("FAIL mul_busy_cycles: got %0d want 16", busy_cycles); end
        checks++;
        if (result !== 16'h03A8) begin errors++; $display("FAIL mul_result: got %h want 03a8", result); end
        checks++;
        if (flags !== 5'b11001) begin errors++; $display("FAIL mul_flags: got %b want 11001", flags); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        issue(OP_XOR, 16'h00FF, 16'h0F0F, 4'h0, 1'b0);
        // A second op waits at the input while the result is stalled
        alu_cont = OP_ADD;
        dst      = 16'h0001;
        src      = 16'h0001;
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d: got %b want 0", k, in_ready); end
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid cyc%0d: got %b want 1", k, out_valid); end
            checks++;
            if (result !== 16'h0FF0) begin errors++; $display("FAIL bp_result cyc%0d: got %h want 0ff0", k, result); end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: out_valid=%b want 0", out_valid); end
        step();
        checks++;
        if (out_valid !== 1'b0 || result !== 16'h0FF0) begin
            errors++;
            $display("FAIL bp_single_transfer: out_valid=%b result=%h want 0/0ff0", out_valid, result);
        end
    endtask

    task automatic test_flush();
        int stray;
        stray = 0;
        issue(OP_MUL, 16'h0012, 16'h0034, 4'h0, 1'b0);
        for (int k = 0; k < 7; k++) step();
        flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
        step();
        flush = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle: in_ready=%b want 1", in_ready); end
        for (int k = 0; k < 20; k++) begin
            if (out_valid) stray++;
            step();
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL flush_stray_result: got %0d valid cycles want 0", stray); end
        issue(OP_ADD, 16'h0002, 16'h0003, 4'h0, 1'b0);
        checks++;
        if (result !== 16'h0005) begin errors++; $display("FAIL flush_add_result: got %h want 0005", result); end
        checks++;
        if (flags !== 5'b11001) begin errors++; $display("FAIL flush_flags: got %b want 11001", flags); end
    endtask

    task automatic test_reset_mid_mul();
        int stray;
        stray = 0;
        issue(OP_MUL, 16'h0012, 16'h0034, 4'h0, 1'b0);
        for (int k = 0; k < 7; k++) step();
        reset = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0 || flags !== 5'h00) begin
            errors++;
            $display("FAIL rst_mul_state: out_valid=%b flags=%b want 0/00000", out_valid, flags);
        end
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mul_idle: in_ready=%b want 1", in_ready); end
        for (int k = 0; k < 20; k++) begin
            if (out_valid) stray++;
            step();
        end
        checks++;
        if (stray != 0) begin errors++; $display("FAIL rst_mul_stray: got %0d valid cycles want 0", stray); end
        // 7FFF+1 overflows signed: C=0 F=1
        issue(OP_ADD, 16'h7FFF, 16'h0001, 4'h0, 1'b1);
        checks++;
        if (result !== 16'h8000) begin errors++; $display("FAIL rst_add_result: got %h want 8000", result); end
        checks++;
        if (flags !== 5'b00100) begin errors++; $display("FAIL rst_add_flags: got %b want 00100", flags); end
    endtask

    initial begin
        test_reset();
        test_add_flags();
        test_cmp_branch();
        test_single_cycle_ops();
        test_shifts();
        test_multiply();
        test_backpressure();
        test_flush();
        test_reset_mid_mul();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
